// File: rtl/floor_request_scheduler_if.sv
// rtl/floor_request_scheduler_if.sv - button/car-position inputs and scheduler outputs
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
  logic [NUM_FLOORS-1:0] btn;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  at_floor;
  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    target;
  logic                  target_vld;
  logic                  dir_up;
  logic                  dir_dn;

  // Button panel / car position side
  modport master (
    output btn, cur_floor, at_floor,
    input  req, target, target_vld, dir_up, dir_dn
  );

  // Scheduler side
  modport slave (
    input  btn, cur_floor, at_floor,
    output req, target, target_vld, dir_up, dir_dn
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// rtl/floor_request_scheduler.sv - latched floor calls with SCAN up/down sweep scheduling
module floor_request_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  floor_request_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [NUM_FLOORS-1:0] req_q;
  logic [FLOOR_W-1:0]    target_q;
  logic [FLOOR_W-1:0]    tgt_nxt;
  logic                  vld_q;
  logic                  up_q;
  logic                  dn_q;

  logic                  valid;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] pend;
  logic                  above;
  logic                  below;
  logic [FLOOR_W-1:0]    lo_above;
  logic [FLOOR_W-1:0]    hi_below;

  // Service mask, pending-above/below search and SCAN next-state selection
  always_comb begin
    valid    = ({1'b0, bus.cur_floor} < (FLOOR_W+1)'(NUM_FLOORS));
    clr      = '0;
    above    = 1'b0;
    below    = 1'b0;
    lo_above = '0;
    hi_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr[i] = bus.at_floor & valid & (bus.cur_floor == FLOOR_W'(i));
    end
    pend = req_q & ~clr;
    // Descending scan: last hit is the lowest pending floor above the car
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend[i] && (FLOOR_W'(i) > bus.cur_floor)) begin
        above    = 1'b1;
        lo_above = FLOOR_W'(i);
      end
    end
    // Ascending scan: last hit is the highest pending floor below the car
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] && (FLOOR_W'(i) < bus.cur_floor)) begin
        below    = 1'b1;
        hi_below = FLOOR_W'(i);
      end
    end
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = above ? UP   : (below ? DOWN : IDLE);
      UP:      state_nxt = above ? UP   : (below ? DOWN : IDLE);
      DOWN:    state_nxt = below ? DOWN : (above ? UP   : IDLE);
      default: state_nxt = IDLE;
    endcase
    tgt_nxt = '0;
    if (state_nxt == UP) begin
      tgt_nxt = lo_above;
    end else if (state_nxt == DOWN) begin
      tgt_nxt = hi_below;
    end
  end

  // Request latch plus sweep FSM with registered target/direction decodes;
  // the FSM freezes while the reported floor index is out of range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      state    <= IDLE;
      target_q <= '0;
      vld_q    <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      req_q <= (req_q | bus.btn) & ~clr;
      if (valid) begin
        state    <= state_nxt;
        target_q <= tgt_nxt;
        vld_q    <= (state_nxt != IDLE);
        up_q     <= (state_nxt == UP);
        dn_q     <= (state_nxt == DOWN);
      end
    end
  end

  assign bus.req        = req_q;
  assign bus.target     = target_q;
  assign bus.target_vld = vld_q;
  assign bus.dir_up     = up_q;
  assign bus.dir_dn     = dn_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb/tb_floor_request_scheduler.sv - self-checking bench for floor_request_scheduler
module tb_floor_request_scheduler;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  floor_request_scheduler_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus4 ();
  floor_request_scheduler_if #(.NUM_FLOORS(5), .FLOOR_W(3)) bus5 ();

  floor_request_scheduler #(.NUM_FLOORS(4), .FLOOR_W(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  floor_request_scheduler #(.NUM_FLOORS(5), .FLOOR_W(3)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

  always #5 if (clk_run) clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] cur;
    logic       at;
    logic [3:0] e_req;
    logic [1:0] e_tgt;
    logic       e_vld;
    logic       e_up;
    logic       e_dn;
  } vec_t;

  vec_t vecs[$];

  // Reference model: request set plus sweep direction, rules applied directly
  typedef enum {M_IDLE, M_UP, M_DOWN} mdir_t;
  bit    m_req[4];
  mdir_t m_dir;
  int    m_tgt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_req[i] = 1'b0;
    m_dir = M_IDLE;
    m_tgt = 0;
  endtask

  task automatic model_step(input logic [3:0] b, input int cur, input bit at);
    bit    served[4];
    bit    waiting[4];
    int    nearest_above;
    int    nearest_below;
    mdir_t nd;
    nearest_above = -1;
    nearest_below = -1;
    for (int i = 0; i < 4; i++) begin
      served[i]  = at && (cur < 4) && (cur == i);
      waiting[i] = m_req[i] && !served[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (waiting[i] && i > cur && nearest_above < 0) nearest_above = i;
      if (waiting[i] && i < cur) nearest_below = i;
    end
    for (int i = 0; i < 4; i++) m_req[i] = (m_req[i] || b[i]) && !served[i];
    if (cur < 4) begin
      if (m_dir == M_DOWN)
        nd = (nearest_below >= 0) ? M_DOWN : ((nearest_above >= 0) ? M_UP : M_IDLE);
      else
        nd = (nearest_above >= 0) ? M_UP : ((nearest_below >= 0) ? M_DOWN : M_IDLE);
      m_dir = nd;
      m_tgt = (nd == M_UP) ? nearest_above : ((nd == M_DOWN) ? nearest_below : 0);
    end
  endtask

  function automatic logic [8:0] model_out4();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_req[i];
    return {r, 2'(m_tgt), m_dir != M_IDLE, m_dir == M_UP, m_dir == M_DOWN};
  endfunction

  function automatic logic [8:0] dut_out4();
    return {bus4.req, bus4.target, bus4.target_vld, bus4.dir_up, bus4.dir_dn};
  endfunction

  function automatic logic [10:0] dut_out5();
    return {bus5.req, bus5.target, bus5.target_vld, bus5.dir_up, bus5.dir_dn};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h  {req,target,vld,up,dn}", name, got, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] b, input logic [1:0] cur, input logic at);
    bus4.btn       = b;
    bus4.cur_floor = cur;
    bus4.at_floor  = at;
    @(posedge clk);
    #1;
  endtask

  task automatic drive5(input logic [4:0] b, input logic [2:0] cur, input logic at);
    bus5.btn       = b;
    bus5.cur_floor = cur;
    bus5.at_floor  = at;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic [3:0] rb;
    logic [1:0] rc;
    logic       ra;

    // Stimulus table: applied back to back from reset
    vecs.push_back('{4'b0100, 2'd0, 1'b1, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 2'd0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'b0000, 2'd2, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 2'd2, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b1001, 2'd1, 1'b0, 4'b1001, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 2'd1, 1'b0, 4'b1001, 2'd3, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'b0000, 2'd3, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, 2'd0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 2'd1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 2'd1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 2'd1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 2'd2, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 2'd2, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b1000, 2'd2, 1'b0, 4'b1001, 2'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, 2'd2, 1'b0, 4'b1001, 2'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, 2'd0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'b0000, 2'd3, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});

    bus4.btn = '0; bus4.cur_floor = '0; bus4.at_floor = 1'b0;
    bus5.btn = '0; bus5.cur_floor = '0; bus5.at_floor = 1'b0;
    rst_n = 1'b1;

    // Asynchronous reset with the clock stopped
    #2 rst_n = 1'b0;
    #1;
    check("reset_async4", 32'(dut_out4()), 32'h0);
    check("reset_async5", 32'(dut_out5()), 32'h0);
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive4(4'b0000, 2'd0, 1'b0);
    drive4(4'b0000, 2'd0, 1'b0);
    check("reset_release", 32'(dut_out4()), 32'h0);
    model_reset();

    // Directed table
    foreach (vecs[k]) begin
      drive4(vecs[k].btn, vecs[k].cur, vecs[k].at);
      check($sformatf("vec%0d", k), 32'(dut_out4()),
            32'({vecs[k].e_req, vecs[k].e_tgt, vecs[k].e_vld, vecs[k].e_up, vecs[k].e_dn}));
    end

    // Reset between edges while sweeping up
    pulse_reset();
    drive4(4'b1000, 2'd1, 1'b0);
    drive4(4'b0000, 2'd1, 1'b0);
    check("pre_midreset_up", 32'(dut_out4()), 32'({4'b1000, 2'd3, 3'b110}));
    #2 rst_n = 1'b0;
    #1;
    check("midreset_immediate", 32'(dut_out4()), 32'h0);
    #1 rst_n = 1'b1;
    drive4(4'b0000, 2'd1, 1'b0);
    check("midreset_dropped", 32'(dut_out4()), 32'h0);
    drive4(4'b0001, 2'd2, 1'b0);
    drive4(4'b0000, 2'd2, 1'b0);
    check("post_reset_press", 32'(dut_out4()), 32'({4'b0001, 2'd0, 3'b101}));

    // Randomized run against the reference model
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      rb = 4'($urandom & $urandom & $urandom);
      rc = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 2) != 0);
      model_step(rb, int'(rc), ra);
      drive4(rb, rc, ra);
      check($sformatf("rand%0d", c), 32'(dut_out4()), 32'(model_out4()));
    end

    // Five floors: out-of-range floor index freezes clears and the FSM
    drive4(4'b0000, 2'd0, 1'b0);
    pulse_reset();
    drive5(5'b00100, 3'd0, 1'b0);
    check("f5_latch", 32'(dut_out5()), 32'({5'b00100, 3'd0, 3'b000}));
    drive5(5'b00000, 3'd0, 1'b0);
    check("f5_up", 32'(dut_out5()), 32'({5'b00100, 3'd2, 3'b110}));
    drive5(5'b00000, 3'd6, 1'b1);
    check("f5_invalid6_hold", 32'(dut_out5()), 32'({5'b00100, 3'd2, 3'b110}));
    drive5(5'b00000, 3'd7, 1'b1);
    check("f5_invalid7_hold", 32'(dut_out5()), 32'({5'b00100, 3'd2, 3'b110}));
    drive5(5'b00000, 3'd2, 1'b1);
    check("f5_clear2", 32'(dut_out5()), 32'({5'b00000, 3'd0, 3'b000}));
    drive5(5'b10000, 3'd5, 1'b1);
    check("f5_latch_while_invalid", 32'(dut_out5()), 32'({5'b10000, 3'd0, 3'b000}));
    drive5(5'b00000, 3'd4, 1'b1);
    check("f5_clear_top", 32'(dut_out5()), 32'({5'b00000, 3'd0, 3'b000}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
